tero_avg_accumulator: RTL and testbench
=======================================

TERO_AVG_ACCUMULATOR -- requirements
Module: tero_avg_accumulator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_LOOPS, 4, number of TERO loops; even, >=2.
- COUNT_BITS, 16, width of one evaluation's oscillation count.
- LOG2_REPS, 4, log2 of repetitions per loop; average = sum >> LOG2_REPS.
- SEL_W = max(1, clog2(NUM_LOOPS)), derived, not overridable.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- reset_puf, in, 1, controller clears the current loop evaluation.
- enable_puf, in, 1, evaluation window active.
- select_puf, in, SEL_W, index of the loop under evaluation.
- sample_valid, in, 1, one-cycle pulse; count_in holds a completed evaluation.
- count_in, in, COUNT_BITS, oscillation count for one evaluation.
- store_response_puf, in, 1, one-cycle pulse; average and store the current loop.
- clear, in, 1, one-cycle pulse; invalidates the bank for a new challenge.
- next_enable, out, 1, bank written; controller may advance.
- rd_addr, in, SEL_W, bank read index.
- rd_data, out, COUNT_BITS, bank[rd_addr], combinational read.
- response_bits, out, NUM_LOOPS/2, bit i = (bank[2i] > bank[2i+1]).
- response_valid, out, 1, all NUM_LOOPS entries written since the last clear/reset.
- rep_error, out, 1, sticky: wrong sample count or illegal select.

Function
REQ-003 The FSM SHALL have 4 states: IDLE, ACCUM, WRITE, READY.
REQ-004 reset_puf SHALL, in any state, clear acc and the sample counter and move to IDLE next cycle; it has priority over every other input in that cycle.
REQ-005 IDLE SHALL move to ACCUM when enable_puf=1.
REQ-006 In IDLE or ACCUM, sample_valid with enable_puf=1 SHALL add count_in to acc (width COUNT_BITS+LOG2_REPS, no overflow) and increment the sample counter.
REQ-007 sample_valid with enable_puf=0, or in WRITE/READY, SHALL be ignored.
REQ-008 The sample counter SHALL saturate at 2**LOG2_REPS; a further accepted sample SHALL set rep_error.
REQ-009 store_response_puf in IDLE/ACCUM SHALL move the FSM to WRITE; a same-cycle sample_valid SHALL be included in the sum first.
REQ-010 WRITE SHALL last one cycle:
- writes bank[select_puf] = acc >> LOG2_REPS (truncated) and sets valid_mask[select_puf];
- sets rep_error if the sample count != 2**LOG2_REPS;
- moves to READY.
REQ-011 select_puf >= NUM_LOOPS in WRITE SHALL skip the bank write, set rep_error, and still move to READY, so the controller never deadlocks.
REQ-012 next_enable SHALL be 1 exactly in READY: it rises 2 cycles after the store_response_puf pulse and holds until reset_puf is sampled.
REQ-013 In READY, store_response_puf SHALL be ignored.
REQ-014 response_valid SHALL equal AND of valid_mask; response_bits SHALL be registered and update the cycle after any bank write.
REQ-015 clear SHALL zero valid_mask and rep_error next cycle and leave bank contents intact; clear with a same-cycle WRITE SHALL leave the written bit set.

Reset
REQ-016 reset SHALL force IDLE and zero acc, counter, bank, valid_mask, next_enable, response_bits, response_valid and rep_error at the next edge.
REQ-017 reset SHALL override all inputs, including mid-ACCUM or in READY.

Structure
REQ-018 Package tero_pkg SHALL hold the state enum, and the SEL_W helper function shared with the controller.
REQ-019 The pairwise comparator SHALL be sub-module tero_pair_compare (NUM_LOOPS/2 unsigned comparisons). All else is inline.

Verification (NUM_LOOPS=4, COUNT_BITS=16, LOG2_REPS=2)
REQ-020 Basic average:
- stimulus: select 0; samples 100, 102, 98, 104; then store;
- response: bank[0]=101; next_enable=1 two cycles after store, held until reset_puf, then 0.
REQ-021 Full run:
- stimulus: loop averages 200, 150, 90, 91;
- response: response_bits=2'b01, response_valid=1, rep_error=0.
REQ-022 Same-cycle sample and store:
- stimulus: samples 10, 10, 10, then 14 in the same cycle as store;
- response: bank entry = 11.
REQ-023 Short count:
- stimulus: 3 samples of 40, then store;
- response: bank=30, rep_error=1; clear returns rep_error and response_valid to 0.
REQ-024 Reset mid-ACCUM:
- stimulus: reset asserted after 2 samples;
- response: all outputs 0 next cycle; a fresh 4-sample run averages correctly.
REQ-025 Max values:
- stimulus: 4 samples of 0xFFFF;
- response: bank=0xFFFF, no wrap.

Source files
------------

// File: rtl/tero_pkg.sv
// Shared types and helpers for the TERO PUF averaging datapath and its controller.
package tero_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2,
    ST_READY = 2'd3
  } tero_state_e;

  // Loop-select width; a single loop pair still needs a one-bit select.
  function automatic int sel_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tero_pair_compare.sv
// Pairwise unsigned comparison of adjacent bank entries; bit i = entry[2i] > entry[2i+1].
module tero_pair_compare #(
  parameter int NUM_LOOPS  = 4,
  parameter int COUNT_BITS = 16
) (
  input  logic [NUM_LOOPS*COUNT_BITS-1:0] bank_flat,
  output logic [NUM_LOOPS/2-1:0]          greater
);

  for (genvar i = 0; i < NUM_LOOPS / 2; i++) begin : g_pair
    assign greater[i] = bank_flat[(2*i)*COUNT_BITS +: COUNT_BITS] >
                        bank_flat[(2*i+1)*COUNT_BITS +: COUNT_BITS];
  end

endmodule

// File: rtl/tero_avg_accumulator.sv
// Accumulates repeated TERO oscillation counts per loop, stores the average in a bank
// and derives the pairwise response bits once every loop has been evaluated.
module tero_avg_accumulator
  import tero_pkg::*;
#(
  parameter int  NUM_LOOPS  = 4,
  parameter int  COUNT_BITS = 16,
  parameter int  LOG2_REPS  = 4,
  localparam int SEL_W      = sel_width(NUM_LOOPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reset_puf,
  input  logic                   enable_puf,
  input  logic [SEL_W-1:0]       select_puf,
  input  logic                   sample_valid,
  input  logic [COUNT_BITS-1:0]  count_in,
  input  logic                   store_response_puf,
  input  logic                   clear,
  output logic                   next_enable,
  input  logic [SEL_W-1:0]       rd_addr,
  output logic [COUNT_BITS-1:0]  rd_data,
  output logic [NUM_LOOPS/2-1:0] response_bits,
  output logic                   response_valid,
  output logic                   rep_error
);

  localparam int ACC_W = COUNT_BITS + LOG2_REPS;
  localparam int CNT_W = LOG2_REPS + 1;
  localparam logic [CNT_W-1:0] REPS      = {1'b1, {LOG2_REPS{1'b0}}};
  localparam logic [SEL_W:0]   LOOPS_LIM = (SEL_W + 1)'(NUM_LOOPS);

  tero_state_e                     state_r, state_next_s;
  logic [ACC_W-1:0]                acc_r, acc_next_s;
  logic [CNT_W-1:0]                cnt_r, cnt_next_s;
  logic                            sample_over_s;
  logic [COUNT_BITS-1:0]           bank_r [NUM_LOOPS];
  logic [NUM_LOOPS-1:0]            valid_mask_r, valid_mask_next_s, write_onehot_s;
  logic                            rep_error_r, rep_error_next_s, rep_set_s;
  logic                            next_enable_r;
  logic [NUM_LOOPS/2-1:0]          response_bits_r, cmp_bits_s;
  logic [NUM_LOOPS*COUNT_BITS-1:0] bank_flat_s;
  logic                            sel_legal_s, rd_legal_s, bank_we_s;
  logic [COUNT_BITS-1:0]           avg_s;

  assign sel_legal_s    = ({1'b0, select_puf} < LOOPS_LIM);
  assign rd_legal_s     = ({1'b0, rd_addr} < LOOPS_LIM);
  assign bank_we_s      = (state_r == ST_WRITE) && sel_legal_s;
  assign avg_s          = acc_r[ACC_W-1:LOG2_REPS];
  assign write_onehot_s = bank_we_s ? (NUM_LOOPS'(1'b1) << select_puf) : '0;

  // Next-state, accumulator and sample-counter update; reset_puf outranks every other input.
  always_comb begin
    state_next_s  = state_r;
    acc_next_s    = acc_r;
    cnt_next_s    = cnt_r;
    sample_over_s = 1'b0;
    if (reset_puf) begin
      state_next_s = ST_IDLE;
      acc_next_s   = '0;
      cnt_next_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (sample_valid && enable_puf) begin
            // A sample past the expected repetition count is flagged, not summed, so acc cannot wrap.
            if (cnt_r == REPS) begin
              sample_over_s = 1'b1;
            end else begin
              acc_next_s = acc_r + {{LOG2_REPS{1'b0}}, count_in};
              cnt_next_s = cnt_r + {{LOG2_REPS{1'b0}}, 1'b1};
            end
          end else begin
            sample_over_s = 1'b0;
          end
          if (store_response_puf) begin
            state_next_s = ST_WRITE;
          end else if (enable_puf) begin
            state_next_s = ST_ACCUM;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_WRITE: state_next_s = ST_READY;
        ST_READY: state_next_s = ST_READY;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  assign rep_set_s = sample_over_s |
                     ((state_r == ST_WRITE) && ((cnt_r != REPS) || !sel_legal_s));
  // A write in the same cycle as clear survives because the write bit is OR-ed in after the clear.
  assign valid_mask_next_s = (clear ? '0 : valid_mask_r) | write_onehot_s;
  assign rep_error_next_s  = (clear ? 1'b0 : rep_error_r) | rep_set_s;

  // FSM state, accumulator and sample counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      acc_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      acc_r   <= acc_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Averaged-count bank, written once per WRITE cycle for a legal select.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        bank_r[i] <= '0;
      end
    end else if (bank_we_s) begin
      bank_r[select_puf] <= avg_s;
    end
  end

  // Bank flattening for the comparator.
  always_comb begin
    bank_flat_s = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      bank_flat_s[i*COUNT_BITS +: COUNT_BITS] = bank_r[i];
    end
  end

  tero_pair_compare #(
    .NUM_LOOPS  (NUM_LOOPS),
    .COUNT_BITS (COUNT_BITS)
  ) u_pair_compare (
    .bank_flat (bank_flat_s),
    .greater   (cmp_bits_s)
  );

  // Status registers: valid mask, sticky error, handshake and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mask_r    <= '0;
      rep_error_r     <= 1'b0;
      next_enable_r   <= 1'b0;
      response_bits_r <= '0;
    end else begin
      valid_mask_r    <= valid_mask_next_s;
      rep_error_r     <= rep_error_next_s;
      next_enable_r   <= (state_next_s == ST_READY);
      response_bits_r <= cmp_bits_s;
    end
  end

  assign rd_data        = rd_legal_s ? bank_r[rd_addr] : '0;
  assign next_enable    = next_enable_r;
  assign response_bits  = response_bits_r;
  assign response_valid = &valid_mask_r;
  assign rep_error      = rep_error_r;

endmodule

// File: tb/tb_tero_avg_accumulator.sv
// Self-checking bench for tero_avg_accumulator against a queue/arithmetic reference model.
module tb_tero_avg_accumulator;

  localparam int NL = 4;
  localparam int CB = 16;
  localparam int LR = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset, reset_puf, enable_puf, sample_valid, store_response_puf, clear;
  logic [SW-1:0] select_puf, rd_addr;
  logic [CB-1:0] count_in, rd_data;
  logic          next_enable, response_valid, rep_error;
  logic [NL/2-1:0] response_bits;

  int errors = 0;
  int checks = 0;

  int unsigned   bank_m [NL];
  logic [NL-1:0] mask_m;
  logic          err_m;

  always #5 clk = ~clk;

  tero_avg_accumulator #(.NUM_LOOPS(NL), .COUNT_BITS(CB), .LOG2_REPS(LR)) dut (
    .clk(clk), .reset(reset), .reset_puf(reset_puf), .enable_puf(enable_puf),
    .select_puf(select_puf), .sample_valid(sample_valid), .count_in(count_in),
    .store_response_puf(store_response_puf), .clear(clear), .next_enable(next_enable),
    .rd_addr(rd_addr), .rd_data(rd_data), .response_bits(response_bits),
    .response_valid(response_valid), .rep_error(rep_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) bank_m[i] = 0;
    mask_m = '0;
    err_m  = 1'b0;
  endtask

  function automatic logic [NL/2-1:0] model_bits();
    logic [NL/2-1:0] b;
    for (int i = 0; i < NL / 2; i++) b[i] = (bank_m[2*i] > bank_m[2*i+1]);
    return b;
  endfunction

  task automatic global_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  // One loop evaluation: reset_puf, an ignored sample, n samples, store, wait for READY and response.
  task automatic run_loop(input int sel, input int unsigned s0, input int unsigned s1,
                          input int unsigned s2, input int unsigned s3, input int n, input bit clr_w);
    int unsigned smp [4];
    longint unsigned sum;
    smp = '{s0, s1, s2, s3};
    sum = 0;
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    select_puf = SW'(sel);
    sample_valid = 1'b1; enable_puf = 1'b0; count_in = CB'($urandom_range(1, 65535)); step();
    enable_puf = 1'b1;
    for (int i = 0; i < n; i++) begin
      count_in = CB'(smp[i]);
      sum += smp[i];
      step();
    end
    sample_valid = 1'b0;
    store_response_puf = 1'b1; step(); store_response_puf = 1'b0;
    clear = clr_w; step(); clear = 1'b0;
    enable_puf = 1'b0;
    step();
    if (clr_w) begin
      mask_m = '0;
      err_m  = 1'b0;
    end
    bank_m[sel] = int'((sum / 4) % 65536);
    mask_m[sel] = 1'b1;
    if (n != 4) err_m = 1'b1;
  endtask

  task automatic test_reset();
    global_reset();
    step();
    checks++; if (next_enable !== 1'b0) begin errors++; $display("FAIL reset_next_enable got=%0b exp=0", next_enable); end
    checks++; if (response_bits !== 2'b00) begin errors++; $display("FAIL reset_response_bits got=%b exp=00", response_bits); end
    checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL reset_response_valid got=%0b exp=0", response_valid); end
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL reset_rep_error got=%0b exp=0", rep_error); end
    for (int a = 0; a < NL; a++) begin
      rd_addr = SW'(a); #1;
      checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_bank[%0d] got=%0d exp=0", a, rd_data); end
    end
  endtask

  task automatic test_basic_average();
    int unsigned smp [4];
    smp = '{100, 102, 98, 104};
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    select_puf = 2'd0; enable_puf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; count_in = CB'(smp[i]); step();
    end
    sample_valid = 1'b0;
    store_response_puf = 1'b1; step(); store_response_puf = 1'b0;
    checks++; if (next_enable !== 1'b0) begin errors++; $display("FAIL basic_ne_write got=%0b exp=0", next_enable); end
    step();
    checks++; if (next_enable !== 1'b1) begin errors++; $display("FAIL basic_ne_ready got=%0b exp=1", next_enable); end
    enable_puf = 1'b0;
    step(); step(); step();
    checks++; if (next_enable !== 1'b1) begin errors++; $display("FAIL basic_ne_hold got=%0b exp=1", next_enable); end
    bank_m[0] = 101; mask_m[0] = 1'b1;
    rd_addr = 2'd0; #1;
    checks++; if (rd_data !== 16'd101) begin errors++; $display("FAIL basic_bank0 got=%0d exp=101", rd_data); end
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    checks++; if (next_enable !== 1'b0) begin errors++; $display("FAIL basic_ne_drop got=%0b exp=0", next_enable); end
  endtask

  task automatic test_full_run();
    int unsigned avg [4];
    avg = '{200, 150, 90, 91};
    global_reset();
    for (int s = 0; s < NL; s++) run_loop(s, avg[s] - 3, avg[s] + 1, avg[s] + 2, avg[s], 4, 1'b0);
    for (int a = 0; a < NL; a++) begin
      rd_addr = SW'(a); #1;
      checks++; if (rd_data !== CB'(avg[a])) begin errors++; $display("FAIL full_bank[%0d] got=%0d exp=%0d", a, rd_data, avg[a]); end
    end
    checks++; if (response_bits !== 2'b01) begin errors++; $display("FAIL full_bits got=%b exp=01", response_bits); end
    checks++; if (response_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%0b exp=1", response_valid); end
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL full_rep_error got=%0b exp=0", rep_error); end
  endtask

  task automatic test_same_cycle();
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    select_puf = 2'd2; enable_puf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; count_in = 16'd10; step();
    end
    count_in = 16'd14; store_response_puf = 1'b1; step();
    sample_valid = 1'b0; store_response_puf = 1'b0; enable_puf = 1'b0;
    step(); step();
    bank_m[2] = 11; mask_m[2] = 1'b1;
    rd_addr = 2'd2; #1;
    checks++; if (rd_data !== 16'd11) begin errors++; $display("FAIL same_cycle_bank got=%0d exp=11", rd_data); end
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL same_cycle_rep_error got=%0b exp=0", rep_error); end
    checks++; if (response_bits !== model_bits()) begin errors++; $display("FAIL same_cycle_bits got=%b exp=%b", response_bits, model_bits()); end
  endtask

  task automatic test_short_count();
    run_loop(1, 40, 40, 40, 0, 3, 1'b0);
    rd_addr = 2'd1; #1;
    checks++; if (rd_data !== 16'd30) begin errors++; $display("FAIL short_bank got=%0d exp=30", rd_data); end
    checks++; if (rep_error !== 1'b1) begin errors++; $display("FAIL short_rep_error got=%0b exp=1", rep_error); end
    clear = 1'b1; step(); clear = 1'b0;
    mask_m = '0; err_m = 1'b0;
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL short_clear_err got=%0b exp=0", rep_error); end
    checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL short_clear_valid got=%0b exp=0", response_valid); end
    checks++; if (rd_data !== 16'd30) begin errors++; $display("FAIL short_bank_kept got=%0d exp=30", rd_data); end
  endtask

  task automatic test_extra_sample();
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    select_puf = 2'd3; enable_puf = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; count_in = 16'd7; step();
    end
    sample_valid = 1'b0; enable_puf = 1'b0;
    step();
    checks++; if (rep_error !== 1'b1) begin errors++; $display("FAIL extra_sample_err got=%0b exp=1", rep_error); end
    clear = 1'b1; step(); clear = 1'b0;
    err_m = 1'b0; mask_m = '0;
  endtask

  task automatic test_reset_mid_accum();
    int unsigned s [4];
    run_loop(3, 5000, 6000, 7000, 8000, 4, 1'b0);
    reset_puf = 1'b1; step(); reset_puf = 1'b0;
    select_puf = 2'd0; enable_puf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1; count_in = 16'd999; step();
    end
    sample_valid = 1'b0; enable_puf = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    model_reset();
    checks++; if (next_enable !== 1'b0) begin errors++; $display("FAIL midrst_ne got=%0b exp=0", next_enable); end
    checks++; if (response_bits !== 2'b00) begin errors++; $display("FAIL midrst_bits got=%b exp=00", response_bits); end
    checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", response_valid); end
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL midrst_err got=%0b exp=0", rep_error); end
    rd_addr = 2'd3; #1;
    checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL midrst_bank3 got=%0d exp=0", rd_data); end
    for (int i = 0; i < 4; i++) s[i] = $urandom_range(0, 65535);
    run_loop(0, s[0], s[1], s[2], s[3], 4, 1'b0);
    rd_addr = 2'd0; #1;
    checks++; if (rd_data !== CB'(bank_m[0])) begin errors++; $display("FAIL midrst_fresh got=%0d exp=%0d", rd_data, bank_m[0]); end
  endtask

  task automatic test_max_values();
    run_loop(1, 65535, 65535, 65535, 65535, 4, 1'b0);
    rd_addr = 2'd1; #1;
    checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL max_bank got=%h exp=ffff", rd_data); end
    checks++; if (rep_error !== 1'b0) begin errors++; $display("FAIL max_err got=%0b exp=0", rep_error); end
  endtask

  task automatic test_ready_ignores();
    run_loop(2, 300, 300, 300, 300, 4, 1'b0);
    select_puf = 2'd3; enable_puf = 1'b1;
    sample_valid = 1'b1; count_in = 16'd500; store_response_puf = 1'b1; step();
    sample_valid = 1'b0; store_response_puf = 1'b0; enable_puf = 1'b0;
    step(); step();
    checks++; if (next_enable !== 1'b1) begin errors++; $display("FAIL ready_ne got=%0b exp=1", next_enable); end
    rd_addr = 2'd3; #1;
    checks++; if (rd_data !== CB'(bank_m[3])) begin errors++; $display("FAIL ready_store_ignored got=%0d exp=%0d", rd_data, bank_m[3]); end
    checks++; if (response_valid !== (&mask_m)) begin errors++; $display("FAIL ready_valid got=%0b exp=%0b", response_valid, &mask_m); end
  endtask

  task automatic test_clear_with_write();
    global_reset();
    for (int s = 0; s < 3; s++) run_loop(s, 1000 * (s + 1), 1000, 2000, 3000, 4, 1'b0);
    run_loop(3, 400, 400, 400, 400, 4, 1'b1);
    checks++; if (response_valid !== 1'b0) begin errors++; $display("FAIL clrw_valid got=%0b exp=0", response_valid); end
    for (int s = 0; s < 3; s++) run_loop(s, 10, 20, 30, 40, 4, 1'b0);
    checks++; if (response_valid !== 1'b1) begin errors++; $display("FAIL clrw_kept_bit got=%0b exp=1", response_valid); end
    checks++; if (response_bits !== model_bits()) begin errors++; $display("FAIL clrw_bits got=%b exp=%b", response_bits, model_bits()); end
  endtask

  task automatic test_random();
    int sel, n;
    int unsigned s [4];
    global_reset();
    for (int r = 0; r < 12; r++) begin
      sel = $urandom_range(0, NL - 1);
      n   = (r % 4 == 3) ? 3 : 4;
      for (int i = 0; i < 4; i++) s[i] = $urandom_range(0, 65535);
      run_loop(sel, s[0], s[1], s[2], s[3], n, 1'b0);
      rd_addr = SW'(sel); #1;
      checks++; if (rd_data !== CB'(bank_m[sel])) begin errors++; $display("FAIL rand_bank[%0d] got=%0d exp=%0d", sel, rd_data, bank_m[sel]); end
      checks++; if (response_bits !== model_bits()) begin errors++; $display("FAIL rand_bits got=%b exp=%b", response_bits, model_bits()); end
      checks++; if (response_valid !== (&mask_m)) begin errors++; $display("FAIL rand_valid got=%0b exp=%0b", response_valid, &mask_m); end
      checks++; if (rep_error !== err_m) begin errors++; $display("FAIL rand_err got=%0b exp=%0b", rep_error, err_m); end
    end
  endtask

  initial begin
    reset = 1'b1; reset_puf = 1'b0; enable_puf = 1'b0; sample_valid = 1'b0;
    store_response_puf = 1'b0; clear = 1'b0; select_puf = '0; rd_addr = '0; count_in = '0;
    model_reset();
    test_reset();
    test_basic_average();
    test_full_run();
    test_same_cycle();
    test_short_count();
    test_extra_sample();
    test_reset_mid_accum();
    test_max_values();
    test_ready_ignores();
    test_clear_with_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
